// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the multiplexed 8-digit 7-segment display scheduler.
package display_pkg;

  typedef logic [7:0][6:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } owner_e;

  localparam logic [6:0] BLANK_SEG  = 7'h7F;
  localparam logic [7:0] ALL_OFF_AN = 8'hFF;

  function automatic logic [1:0] owner_grant(owner_e o);
    case (o)
      OWN0:    return 2'b01;
      OWN1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Producer-side request/frame bus and physical display pins of the scheduler.
interface display_scheduler_if;
  import display_pkg::*;

  logic [1:0] req;
  frame_t     frame0;
  frame_t     frame1;
  logic [1:0] grant;
  logic       frame_done;
  logic [7:0] an;
  logic [6:0] seg;

  modport master (
    output req, frame0, frame1,
    input  grant, frame_done, an, seg
  );

  modport slave (
    input  req, frame0, frame1,
    output grant, frame_done, an, seg
  );

endinterface

// File: rtl/display_scheduler_digit_scanner.sv
// Slot/digit counters plus registered anode/segment decode with per-slot blanking.
module digit_scanner
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000,
  parameter int unsigned BLANK    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart_i,
  input  logic       en_i,
  input  frame_t     snap_i,
  output logic       fb_o,
  output logic [7:0] an_o,
  output logic [6:0] seg_o
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             slot_end;

  assign slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign fb_o     = slot_end && (digit_q == 3'd7);

  // Pins are decoded from next-state cnt/digit/snap so they line up with the counters.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (restart_i) begin
      cnt_d   = '0;
      digit_d = '0;
    end else if (slot_end) begin
      cnt_d   = '0;
      digit_d = (digit_q == 3'd7) ? 3'd0 : digit_q + 3'd1;
    end
    an_d  = ALL_OFF_AN;
    seg_d = BLANK_SEG;
    if (en_i && (cnt_d >= CNT_W'(BLANK))) begin
      an_d  = ~(8'b1 << digit_d);
      seg_d = snap_i[digit_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      digit_q <= '0;
      an_q    <= ALL_OFF_AN;
      seg_q   <= BLANK_SEG;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: rtl/display_scheduler.sv
// Round-robin frame-boundary arbiter between two frame producers sharing one scanned display.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned BLANK      = 16,
  parameter int unsigned MAX_FRAMES = 4
) (
  input logic                 clk,
  input logic                 reset,
  display_scheduler_if.slave  bus
);

  localparam int unsigned HELD_W = $clog2(MAX_FRAMES + 1);

  owner_e            state_q, state_d;
  frame_t            snap_q, snap_d;
  logic [HELD_W-1:0] held_q, held_d;
  logic              rr_q, rr_d;
  logic              frame_done_q, frame_done_d;
  logic              restart;
  logic              fb;
  logic              own_req, oth_req;

  assign own_req = (state_q == OWN1) ? bus.req[1] : bus.req[0];
  assign oth_req = (state_q == OWN1) ? bus.req[0] : bus.req[1];

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    held_d       = held_q;
    rr_d         = rr_q;
    frame_done_d = 1'b0;
    restart      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          restart      = 1'b1;
          frame_done_d = 1'b1;
          held_d       = '0;
          if (bus.req[0] && (!bus.req[1] || !rr_q)) begin
            state_d = OWN0;
            snap_d  = bus.frame0;
          end else begin
            state_d = OWN1;
            snap_d  = bus.frame1;
          end
        end
      end
      OWN0, OWN1: begin
        if (fb) begin
          if (!own_req && !oth_req) begin
            state_d = IDLE;
            held_d  = '0;
          end else if (oth_req && (!own_req || held_q >= HELD_W'(MAX_FRAMES - 1))) begin
            frame_done_d = 1'b1;
            held_d       = '0;
            rr_d         = (state_q == OWN1);
            state_d      = (state_q == OWN1) ? OWN0 : OWN1;
            snap_d       = (state_q == OWN1) ? bus.frame0 : bus.frame1;
          end else begin
            // Staying owner is re-snapshotted so its latest image shows next frame.
            frame_done_d = 1'b1;
            snap_d       = (state_q == OWN1) ? bus.frame1 : bus.frame0;
            if (held_q != HELD_W'(MAX_FRAMES)) held_d = held_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      snap_q       <= '1;
      held_q       <= '0;
      rr_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      held_q       <= held_d;
      rr_q         <= rr_d;
      frame_done_q <= frame_done_d;
    end
  end

  digit_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK    (BLANK)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .en_i      (state_d != IDLE),
    .snap_i    (snap_d),
    .fb_o      (fb),
    .an_o      (bus.an),
    .seg_o     (bus.seg)
  );

  assign bus.grant      = owner_grant(state_q);
  assign bus.frame_done = frame_done_q;

endmodule
